nanoproc_gen: RTL and testbench

Parametrised successor to the 8-bit nanoprocessor core. Width-generic accumulator machine with integrated sequencer and ALU, a hardware return stack for CALL/RET, immediate load, a HALT state, and a `ram_ready` wait-state handshake so it can sit on slow or shared RAM. It connects to the same single-port RAM and LED/buzzer output register as the existing core.

---
 rtl/nanoproc_gen.sv | 147 ++++++++++++++
 tb/tb_nanoproc_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/nanoproc_gen.sv
// nanoproc_gen: width-generic accumulator core (ram_* RAM port with ready handshake, out LED register, I debug, halted, stk_err sticky)
module nanoproc_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_data_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_write,
  output logic [DATA_W-1:0] out,
  output logic [DATA_W-1:0] I,
  output logic              halted,
  output logic              stk_err
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
  typedef enum logic [1:0] {FETCH_I, FETCH_OP, EXEC, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ad_q, ad_d;
  logic [DATA_W-1:0] i_q, i_d, acc_q, acc_d, out_q, out_d, bx, res;
  logic [DATA_W:0] sum;
  logic c_q, c_d, z_q, z_d, err_q, err_d, push, pop, taken, cres;
  logic [SPW-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic [3:0] op, sub;
  assign op = i_q[7:4];
  assign sub = i_q[3:0];
  assign bx = sub[1] ? ~ram_data_read : ram_data_read;
  assign sum = {1'b0, acc_q} + {1'b0, bx} + (DATA_W+1)'(sub[0] ? c_q : sub[1]);
  assign taken = i_q[1] ? (i_q[0] ? !z_q : c_q) : (i_q[0] ? z_q : 1'b1);
  assign ram_addr = state_q == EXEC ? ad_q : pc_q;
  assign ram_write = state_q == EXEC && op == 4'd1;
  assign ram_data_write = acc_q;
  assign out = out_q;
  assign I = i_q;
  assign halted = state_q == HALT;
  assign stk_err = err_q;
  always_comb begin
    res = acc_q;
    cres = c_q;
    case (sub)
      4'd0: res = acc_q | ram_data_read;
      4'd1: res = acc_q ^ ram_data_read;
      4'd2: res = acc_q & ram_data_read;
      4'd3: res = ram_data_read;
      4'd4, 4'd5, 4'd6, 4'd7: {cres, res} = sum;
      4'd8: {cres, res} = {acc_q, c_q};
      4'd9: {res, cres} = {c_q, acc_q};
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ad_d = ad_q;
    i_d = i_q;
    acc_d = acc_q;
    out_d = out_q;
    c_d = c_q;
    z_d = z_q;
    err_d = err_q;
    sp_d = sp_q;
    push = 1'b0;
    pop = 1'b0;
    if (ram_ready) begin
      case (state_q)
        FETCH_I: begin
          i_d = ram_data_read;
          pc_d = pc_q + ADDR_W'(1);
          state_d = FETCH_OP;
        end
        FETCH_OP: begin
          ad_d = ram_data_read[ADDR_W-1:0];
          pc_d = pc_q + ADDR_W'(1);
          state_d = op <= 4'd2 ? EXEC : op == 4'd7 ? HALT : FETCH_I;
          if (op == 4'd3 && taken) pc_d = ram_data_read[ADDR_W-1:0];
          if (op == 4'd4) begin
            if (sp_q == SP_FULL) err_d = 1'b1;
            else begin
              push = 1'b1;
              sp_d = sp_q + SPW'(1);
              pc_d = ram_data_read[ADDR_W-1:0];
            end
          end
          if (op == 4'd5) begin
            if (sp_q == '0) err_d = 1'b1;
            else begin
              pop = 1'b1;
              sp_d = sp_q - SPW'(1);
              pc_d = stk_q[0];
            end
          end
          if (op == 4'd6) begin
            acc_d = ram_data_read;
            z_d = ram_data_read == '0;
          end
        end
        EXEC: begin
          state_d = FETCH_I;
          if (op == 4'd0 && sub <= 4'd9) begin
            acc_d = res;
            c_d = cres;
            z_d = res == '0;
          end
          if (op == 4'd2) out_d = ram_data_read;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH_I;
      pc_q <= '0;
      ad_q <= '0;
      i_q <= '0;
      acc_q <= '0;
      out_q <= '0;
      c_q <= 1'b0;
      z_q <= 1'b0;
      err_q <= 1'b0;
      sp_q <= '0;
      for (int k = 0; k < STACK_DEPTH; k++) stk_q[k] <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ad_q <= ad_d;
      i_q <= i_d;
      acc_q <= acc_d;
      out_q <= out_d;
      c_q <= c_d;
      z_q <= z_d;
      err_q <= err_d;
      sp_q <= sp_d;
      if (push) begin
        stk_q[0] <= pc_q + ADDR_W'(1);
        for (int k = 1; k < STACK_DEPTH; k++) stk_q[k] <= stk_q[k-1];
      end else if (pop) begin
        for (int k = 0; k < STACK_DEPTH - 1; k++) stk_q[k] <= stk_q[k+1];
      end
    end
  end
endmodule

// File: tb/tb_nanoproc_gen.sv
// tb_nanoproc_gen: directed checks of nanoproc_gen at 8/8/4 and 12/10/4
module tb_nanoproc_gen;
  logic clk = 1'b0;
  logic reset = 1'b1, reset12 = 1'b1, ready = 1'b1, ready12 = 1'b1;
  logic [7:0] mem [256];
  logic [11:0] mem12 [1024];
  logic [7:0] rd, wd, out8, i8, addr8;
  logic [11:0] rd12, wd12, out12, i12;
  logic [9:0] addr12;
  logic wr8, wr12, halt8, halt12, err8, err12;
  int checks = 0, errors = 0, wcnt = 0, w0;
  logic [7:0] stk_exp [10];
  always #5 clk = ~clk;
  assign rd = mem[addr8];
  assign rd12 = mem12[addr12];
  nanoproc_gen dut (
    .clk(clk), .reset(reset), .ram_ready(ready), .ram_data_read(rd), .ram_write(wr8),
    .ram_addr(addr8), .ram_data_write(wd), .out(out8), .I(i8), .halted(halt8), .stk_err(err8)
  );
  nanoproc_gen #(.DATA_W(12), .ADDR_W(10), .STACK_DEPTH(4)) dut12 (
    .clk(clk), .reset(reset12), .ram_ready(ready12), .ram_data_read(rd12), .ram_write(wr12),
    .ram_addr(addr12), .ram_data_write(wd12), .out(out12), .I(i12), .halted(halt12), .stk_err(err12)
  );
  always @(posedge clk) begin
    if (wr8 && ready) begin
      mem[addr8] <= wd;
      wcnt <= wcnt + 1;
    end
    if (wr12 && ready12) mem12[addr12] <= wd12;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_mem();
    for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
  endtask
  task automatic restart();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask
  initial begin
    for (int k = 0; k < 1024; k++) mem12[k] <= 12'h000;
    clear_mem();
    mem[8'h00] <= 8'h60; mem[8'h01] <= 8'h05;
    mem[8'h02] <= 8'h04; mem[8'h03] <= 8'h10;
    mem[8'h04] <= 8'h10; mem[8'h05] <= 8'h11;
    mem[8'h06] <= 8'h70; mem[8'h07] <= 8'h00;
    mem[8'h10] <= 8'h03;
    restart();
    chk("rst_addr", 32'(addr8), 32'h00);
    chk("rst_write", 32'(wr8), 32'h0);
    chk("rst_halted", 32'(halt8), 32'h0);
    chk("rst_stkerr", 32'(err8), 32'h0);
    chk("rst_out", 32'(out8), 32'h00);
    chk("rst_I", 32'(i8), 32'h00);
    chk("rst_acc", 32'(wd), 32'h00);
    tick(9);
    chk("t1_not_yet_halted", 32'(halt8), 32'h0);
    tick(1);
    chk("t1_halted", 32'(halt8), 32'h1);
    chk("t1_mem11", 32'(mem[8'h11]), 32'h08);
    chk("t1_acc", 32'(wd), 32'h08);
    chk("t1_addr", 32'(addr8), 32'h08);
    tick(3);
    chk("t1_addr_frozen", 32'(addr8), 32'h08);
    chk("t1_write_quiet", 32'(wr8), 32'h0);
    clear_mem();
    mem[8'h00] <= 8'h60; mem[8'h01] <= 8'hFF;
    mem[8'h02] <= 8'h04; mem[8'h03] <= 8'h80;
    mem[8'h04] <= 8'h33; mem[8'h05] <= 8'h30;
    mem[8'h06] <= 8'h31; mem[8'h07] <= 8'h40;
    mem[8'h40] <= 8'h32; mem[8'h41] <= 8'h50;
    mem[8'h50] <= 8'h10; mem[8'h51] <= 8'h81;
    mem[8'h52] <= 8'h20; mem[8'h53] <= 8'h80;
    mem[8'h54] <= 8'h70; mem[8'h55] <= 8'h00;
    mem[8'h80] <= 8'h01; mem[8'h81] <= 8'h77;
    restart();
    tick(7);
    chk("t2_jnz_not_taken", 32'(addr8), 32'h06);
    tick(2);
    chk("t2_jz_taken", 32'(addr8), 32'h40);
    tick(2);
    chk("t2_jc_taken", 32'(addr8), 32'h50);
    tick(3);
    chk("t2_sta_zero", 32'(mem[8'h81]), 32'h00);
    tick(3);
    chk("t2_out", 32'(out8), 32'h01);
    tick(2);
    chk("t2_halted", 32'(halt8), 32'h1);
    chk("t2_acc", 32'(wd), 32'h00);
    clear_mem();
    mem[8'h00] <= 8'h40; mem[8'h01] <= 8'h10;
    mem[8'h10] <= 8'h40; mem[8'h11] <= 8'h20;
    mem[8'h20] <= 8'h40; mem[8'h21] <= 8'h30;
    mem[8'h30] <= 8'h40; mem[8'h31] <= 8'h40;
    mem[8'h40] <= 8'h40; mem[8'h41] <= 8'h50;
    mem[8'h42] <= 8'h50; mem[8'h32] <= 8'h50; mem[8'h22] <= 8'h50;
    mem[8'h12] <= 8'h50; mem[8'h02] <= 8'h50; mem[8'h04] <= 8'h70;
    stk_exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h42, 8'h32, 8'h22, 8'h12, 8'h02, 8'h04};
    restart();
    for (int n = 0; n < 10; n++) begin
      tick(2);
      chk($sformatf("t3_pc_step%0d", n), 32'(addr8), 32'(stk_exp[n]));
      if (n == 3) chk("t3_err_after_4_calls", 32'(err8), 32'h0);
      if (n == 4) chk("t3_err_after_5th_call", 32'(err8), 32'h1);
    end
    clear_mem();
    mem[8'h00] <= 8'h60; mem[8'h01] <= 8'h5A;
    mem[8'h02] <= 8'h10; mem[8'h03] <= 8'h20;
    mem[8'h04] <= 8'h70;
    restart();
    w0 = wcnt;
    tick(4);
    chk("t4_write_c0", 32'(wr8), 32'h1);
    chk("t4_addr_c0", 32'(addr8), 32'h20);
    ready = 1'b0;
    for (int n = 1; n < 4; n++) begin
      tick(1);
      chk($sformatf("t4_write_c%0d", n), 32'(wr8), 32'h1);
      chk($sformatf("t4_addr_c%0d", n), 32'(addr8), 32'h20);
    end
    chk("t4_no_early_write", 32'(wcnt - w0), 32'd0);
    ready = 1'b1;
    tick(1);
    chk("t4_one_write", 32'(wcnt - w0), 32'd1);
    chk("t4_mem20", 32'(mem[8'h20]), 32'h5A);
    chk("t4_write_done", 32'(wr8), 32'h0);
    chk("t4_next_fetch", 32'(addr8), 32'h04);
    clear_mem();
    mem[8'h00] <= 8'h50; mem[8'h01] <= 8'h00;
    mem[8'h02] <= 8'h60; mem[8'h03] <= 8'h5A;
    mem[8'h04] <= 8'h10; mem[8'h05] <= 8'h20;
    mem[8'h06] <= 8'h70;
    restart();
    tick(2);
    chk("t5_ret_underflow_err", 32'(err8), 32'h1);
    chk("t5_ret_fallthrough", 32'(addr8), 32'h02);
    tick(4);
    chk("t5_sta_exec", 32'(wr8), 32'h1);
    w0 = wcnt;
    reset = 1'b1;
    #1;
    chk("t5_write_drop", 32'(wr8), 32'h0);
    chk("t5_addr_rst", 32'(addr8), 32'h00);
    chk("t5_err_rst", 32'(err8), 32'h0);
    chk("t5_I_rst", 32'(i8), 32'h00);
    chk("t5_acc_rst", 32'(wd), 32'h00);
    tick(1);
    reset = 1'b0;
    chk("t5_no_write", 32'(wcnt - w0), 32'd0);
    chk("t5_fetch0", 32'(addr8), 32'h00);
    tick(1);
    chk("t5_I_after", 32'(i8), 32'h50);
    mem12[10'h000] <= 12'h060; mem12[10'h001] <= 12'h005;
    mem12[10'h002] <= 12'h006; mem12[10'h003] <= 12'h100;
    mem12[10'h004] <= 12'h010; mem12[10'h005] <= 12'h101;
    mem12[10'h006] <= 12'h032; mem12[10'h007] <= 12'h200;
    mem12[10'h008] <= 12'h030; mem12[10'h009] <= 12'h3FE;
    mem12[10'h3FE] <= 12'hA60; mem12[10'h3FF] <= 12'h000;
    mem12[10'h100] <= 12'h006;
    tick(1);
    reset12 = 1'b0;
    chk("t6_rst_addr", 32'(addr12), 32'h000);
    tick(8);
    chk("t6_sub_result", 32'(mem12[10'h101]), 32'hFFF);
    chk("t6_acc", 32'(wd12), 32'hFFF);
    tick(2);
    chk("t6_jc_not_taken", 32'(addr12), 32'h008);
    tick(2);
    chk("t6_jmp_3fe", 32'(addr12), 32'h3FE);
    tick(2);
    chk("t6_pc_wrap", 32'(addr12), 32'h000);
    chk("t6_I_high_ignored", 32'(i12), 32'hA60);
    chk("t6_ldi_acc", 32'(wd12), 32'h000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
